des_round_ctrl: RTL and testbench
=================================

Name: des_round_ctrl

Overview:
Sequencer for the iterative single-round DES core: expansion box, key-mix XOR, S-boxes and P-box, plus the L/R and C/D key registers. It accepts one block request over a valid/ready handshake and issues the load strobes. It then drives 16 round-enable cycles with the per-round key-schedule shift amount and direction, and presents completion with backpressure. It does not touch data itself; it is the control plane beside the datapath.

Parameters:
NUM_ROUNDS, 16, number of rounds sequenced; only 16 is a supported DES configuration, other values are for bench experiments only.
IDX_W, 4, width of round_idx; must satisfy 2**IDX_W >= NUM_ROUNDS.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  controller can accept a request
in_decrypt  input  1  mode of the request (1 = decrypt), sampled on handshake
abort  input  1  synchronous cancel of an in-flight operation
ld_data  output  1  load IP(plaintext) into L/R this cycle
ld_key  output  1  load PC1(key) into C/D this cycle
round_en  output  1  datapath performs one round this cycle
round_idx  output  IDX_W  current round, 0..NUM_ROUNDS-1
shift_amt  output  2  C/D rotate amount applied this round (0, 1 or 2)
shift_dir  output  1  0 = rotate left (encrypt), 1 = rotate right (decrypt)
last_round  output  1  final round; datapath skips the L/R swap
out_valid  output  1  result in L/R is complete
out_ready  input  1  consumer takes the result
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, LOAD, ROUND, DONE.
- Reset (async, any state): state = IDLE. round_idx = 0, mode register = 0. All strobes, out_valid and busy = 0. in_ready = 1 after reset deasserts.
- IDLE: in_ready = 1. A handshake (in_valid & in_ready) latches in_decrypt into the mode register and moves to LOAD.
- LOAD: exactly one cycle. ld_data = ld_key = 1, round_en = 0. Next state is ROUND with round_idx = 0.
- ROUND: round_en = 1 every cycle. round_idx increments by 1 per cycle.
  - last_round = 1 when round_idx = NUM_ROUNDS-1; next state is DONE and round_idx returns to 0.
  - shift_dir = mode register.
- Shift schedule for encrypt, by round_idx 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. These sum to 28.
- Shift schedule for decrypt: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. These sum to 27 right; combined with the first-round subkey this equals K16 first.
- shift_amt = 0 and shift_dir = mode register whenever round_en = 0.
- DONE: out_valid = 1, held stable until out_ready. A cycle with out_valid & out_ready returns to IDLE.
- in_ready = 0 outside IDLE. There are no overlapping requests; a new request is accepted at the earliest in the cycle after the out handshake.
- Latency: handshake at edge T gives LOAD in cycle T+1, rounds in T+2..T+17, and out_valid from T+18. The fixed latency is 18 cycles when out_ready is held high.
- abort in LOAD, ROUND or DONE: the next state is IDLE, round_idx = 0, and no strobes are issued in the following cycle. abort in IDLE has no effect.
- abort has priority over the out handshake in the same cycle. The result is treated as discarded.
- in_valid with out_ready and no handshake possible is ignored. in_decrypt is not sampled outside the handshake.
- An asynchronous reset mid-ROUND drops the operation immediately. The outputs go to reset values on the reset assertion, not at the clock edge.
- All outputs are registered or decoded only from state, round_idx and the mode register; no input-to-output combinational path.

Decomposition:
- des_pkg: state enumeration, the two 16-entry shift-schedule constants, and the NUM_ROUNDS default.
- Sub-module des_shift_sched: a combinational lookup (round_idx, decrypt) -> shift_amt. It is reused by the key-schedule unit's self-check. Everything else stays in des_round_ctrl.

Test Plan:
1. Encrypt request with out_ready = 1:
   - ld_data and ld_key pulse once at T+1.
   - round_en is high for 16 cycles with round_idx 0..15 and shift_amt 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
   - last_round is high only at idx 15; out_valid at T+18. Shift total = 28.
2. Decrypt request: shift_dir = 1 throughout, shift_amt sequence 0,1,2,...,1, shift total = 27. Hooked to the DES datapath, FIPS vector key 133457799BBCDFF1 with ciphertext 85E813540F0AB405 yields 0123456789ABCDEF.
3. Backpressure: out_ready low for 5 cycles after out_valid. out_valid is held, in_ready stays 0 and a pending in_valid is not accepted. The request is accepted in the cycle after the out handshake.
4. abort asserted at round_idx = 7: the next cycle is IDLE, round_en = 0 and in_ready = 1. A following request restarts from LOAD with round_idx = 0.
5. Async reset pulse mid-ROUND (idx 10) between clock edges: all outputs are 0 immediately. After release, in_ready = 1 and the mode register = 0.
6. Back-to-back requests with in_valid held high and out_ready = 1: in_ready pulses every 19 cycles and the mode from each handshake is applied to its own operation.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types and key-schedule shift tables for the DES round sequencer
package des_pkg;

  localparam int NUM_ROUNDS_DEF = 16;
  localparam int SCHED_LEN      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Left-rotate amounts for encryption; the 28 total returns C/D to their start.
  localparam logic [1:0] ENC_SHIFT [SCHED_LEN] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Right-rotate amounts for decryption; round 0 uses the unrotated PC1 output,
  // which already equals the K16 key state.
  localparam logic [1:0] DEC_SHIFT [SCHED_LEN] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage

// File: rtl/des_shift_sched.sv
// rtl/des_shift_sched.sv - combinational lookup of the C/D rotate amount per round
module des_shift_sched
  import des_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] round_idx,
  input  logic             decrypt,
  output logic [1:0]       shift_amt
);

  logic [3:0] sel;
  logic       in_range;

  // Table lookup; indices beyond the 16-entry DES schedule rotate by zero.
  always_comb begin
    sel       = 4'(round_idx);
    in_range  = (32'(round_idx) < 32'(SCHED_LEN));
    shift_amt = 2'd0;
    if (in_range) begin
      shift_amt = decrypt ? DEC_SHIFT[sel] : ENC_SHIFT[sel];
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// rtl/des_round_ctrl.sv - load/round/done sequencer for the iterative DES datapath
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_decrypt,
  input  logic             abort,
  output logic             ld_data,
  output logic             ld_key,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic [1:0]       shift_amt,
  output logic             shift_dir,
  output logic             last_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  state_t     state;
  logic       mode;
  logic [1:0] sched_amt;

  des_shift_sched #(
    .IDX_W(IDX_W)
  ) u_shift_sched (
    .round_idx(round_idx),
    .decrypt  (mode),
    .shift_amt(sched_amt)
  );

  // Rotation is only meaningful while the datapath is actually rounding.
  assign shift_amt  = round_en ? sched_amt : 2'd0;
  assign shift_dir  = mode;
  assign last_round = round_en && (round_idx == LAST_IDX);

  // Sequencer: every output register is written for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode      <= 1'b0;
      round_idx <= '0;
      in_ready  <= 1'b0;
      ld_data   <= 1'b0;
      ld_key    <= 1'b0;
      round_en  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            mode     <= in_decrypt;
            state    <= ST_LOAD;
            in_ready <= 1'b0;
            ld_data  <= 1'b1;
            ld_key   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          ld_data   <= 1'b0;
          ld_key    <= 1'b0;
          round_idx <= '0;
          if (abort) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            state    <= ST_ROUND;
            round_en <= 1'b1;
          end
        end
        ST_ROUND: begin
          if (abort) begin
            state     <= ST_IDLE;
            round_idx <= '0;
            round_en  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end else if (round_idx == LAST_IDX) begin
            state     <= ST_DONE;
            round_idx <= '0;
            round_en  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            round_idx <= round_idx + 1'b1;
          end
        end
        ST_DONE: begin
          // abort discards the result; either way the controller returns to IDLE
          if (abort || out_ready) begin
            state     <= ST_IDLE;
            round_idx <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          round_idx <= '0;
          in_ready  <= 1'b0;
          ld_data   <= 1'b0;
          ld_key    <= 1'b0;
          round_en  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// tb/tb_des_round_ctrl.sv - self-checking bench for the DES round sequencer
module tb_des_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_decrypt = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       ld_data;
  logic       ld_key;
  logic       round_en;
  logic [3:0] round_idx;
  logic [1:0] shift_amt;
  logic       shift_dir;
  logic       last_round;
  logic       out_valid;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_hs    = 0;

  des_round_ctrl #(
    .NUM_ROUNDS(16),
    .IDX_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_decrypt(in_decrypt),
    .abort     (abort),
    .ld_data   (ld_data),
    .ld_key    (ld_key),
    .round_en  (round_en),
    .round_idx (round_idx),
    .shift_amt (shift_amt),
    .shift_dir (shift_dir),
    .last_round(last_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Key-schedule rule: single rotations at rounds 0, 1, 8 and 15, double elsewhere;
  // decryption skips the rotation before the first round.
  function automatic int model_shift(input bit dec, input int r);
    if (r == 0) return dec ? 0 : 1;
    if (r == 1 || r == 8 || r == 15) return 1;
    return 2;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_round_en"}, round_en, 0);
    chk({tag, "_round_idx"}, round_idx, 0);
    chk({tag, "_shift_amt"}, shift_amt, 0);
    chk({tag, "_strobes"}, {ld_data, ld_key, out_valid, last_round}, 0);
  endtask

  // One request from handshake to completion; abort_at 0..15 aborts at that round,
  // 16 aborts in LOAD, rst_at resets asynchronously at that round, exp_period > 0
  // checks the handshake spacing from the previous one.
  task automatic run_op(input bit mode, input int delay, input int abort_at, input int rst_at,
                        input bit hold_valid, input bit next_mode, input int exp_period);
    int waits = 0;
    int sum = 0;
    while (in_ready !== 1'b1 && waits < 5) begin
      tick;
      waits++;
    end
    chk("in_ready_before_req", in_ready, 1);
    in_valid   = 1'b1;
    in_decrypt = mode;
    out_ready  = (delay == 0);
    tick;
    if (exp_period > 0) chk("handshake_period", cyc - last_hs, exp_period);
    last_hs    = cyc;
    in_valid   = hold_valid;
    in_decrypt = 1'($urandom_range(0, 1));
    chk("load_ld_data", ld_data, 1);
    chk("load_ld_key", ld_key, 1);
    chk("load_round_en", round_en, 0);
    chk("load_in_ready", in_ready, 0);
    chk("load_busy", busy, 1);
    chk("load_shift_dir", shift_dir, mode);
    if (abort_at == 16) begin
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check_idle("abort_load");
      return;
    end
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("round_en", round_en, 1);
      chk("round_idx", round_idx, i);
      chk("shift_amt", shift_amt, model_shift(mode, i));
      chk("shift_dir", shift_dir, mode);
      chk("last_round", last_round, (i == 15));
      chk("round_ld_strobes", {ld_data, ld_key, out_valid, in_ready}, 0);
      sum += int'(shift_amt);
      if (abort_at == i) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check_idle("abort_round");
        return;
      end
      if (rst_at == i) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            {ld_data, ld_key, round_en, round_idx, shift_amt, shift_dir, last_round,
             out_valid, busy, in_ready}, 0);
        #1 rst = 1'b0;
        tick;
        check_idle("after_rst");
        chk("after_rst_mode", shift_dir, 0);
        return;
      end
    end
    tick;
    chk("shift_total", sum, mode ? 27 : 28);
    chk("done_out_valid", out_valid, 1);
    chk("done_round_en", round_en, 0);
    chk("done_shift_amt", shift_amt, 0);
    repeat (delay) begin
      tick;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    tick;
    in_decrypt = next_mode;
    check_idle("after_out_hs");
  endtask

  bit modes[5];

  initial begin
    #2;
    chk("reset_outputs",
        {ld_data, ld_key, round_en, round_idx, shift_amt, shift_dir, last_round,
         out_valid, busy, in_ready}, 0);
    #6 rst = 1'b0;
    tick;
    check_idle("post_reset");

    run_op(1'b0, 0, -1, -1, 1'b0, 1'b0, 0);
    run_op(1'b1, 0, -1, -1, 1'b0, 1'b0, 0);

    run_op(1'b0, 5, -1, -1, 1'b1, 1'b1, 0);
    run_op(1'b1, 0, -1, -1, 1'b0, 1'b0, 24);

    run_op(1'b0, 0, 7, -1, 1'b0, 1'b0, 0);
    run_op(1'b0, 0, -1, -1, 1'b0, 1'b0, 0);

    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_idle("abort_in_idle");

    run_op(1'b1, 0, -1, 10, 1'b0, 1'b0, 0);
    run_op(1'b0, 0, -1, -1, 1'b0, 1'b0, 0);

    for (int k = 0; k < 5; k++) modes[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 4; k++) begin
      run_op(modes[k], 0, -1, -1, (k < 3), modes[k+1], (k > 0) ? 19 : 0);
    end

    for (int k = 0; k < 8; k++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : -1;
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), ab, -1, 1'b0, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
